// File: rtl/smaesh_out_serializer.sv
// Streams one captured masked ciphertext as 4*d 32-bit words, share-major, with a single-entry buffer.
// Latency 1 from capture to first word; out_ready low freezes the word, in_ready only opens on the last transfer.
module smaesh_out_serializer #(
    parameter int d = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [128*d-1:0]     sh_data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int NW = 4 * d;
    localparam int CW = $clog2(NW);
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [128*d-1:0]  buf_q, buf_d;
    logic              at_last;

    assign at_last = (state_q == SEND) && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    buf_d   = sh_data_in;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (in_valid) begin
                            buf_d = sh_data_in;
                        end else begin
                            // Scrub the shares as soon as the ciphertext has left.
                            state_d = IDLE;
                            buf_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = !rst && (state_q == SEND);
        out_last  = !rst && at_last;
        in_ready  = !rst && ((state_q == IDLE) || (at_last && out_ready));
        out_data  = '0;
        // Pure bit selection per word: no gate ever sees two shares of one bit.
        if (out_valid) begin
            for (int w = 0; w < NW; w++) begin
                if (cnt_q == CW'(w)) begin
                    for (int k = 0; k < 32; k++) begin
                        out_data[k] = buf_q[(32 * (w % 4) + k) * d + (w / 4)];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_smaesh_out_serializer.sv
// Directed bench for the output serializer: d=2 and d=3 instances, queue scoreboards with negedge monitors.
module tb_smaesh_out_serializer;

    logic         clk;
    logic         rst;
    logic [255:0] sh2;
    logic         in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
    logic [31:0]  out_data2;
    logic [383:0] sh3;
    logic         in_valid3, in_ready3, out_valid3, out_ready3, out_last3;
    logic [31:0]  out_data3;

    int checks = 0;
    int errors = 0;

    logic [32:0] q2[$];
    logic [32:0] q3[$];
    logic [31:0] rx3[12];
    int          rx3_n = 0;

    smaesh_out_serializer #(.d(2)) dut (
        .clk(clk), .rst(rst), .sh_data_in(sh2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2)
    );

    smaesh_out_serializer #(.d(3)) dut3 (
        .clk(clk), .rst(rst), .sh_data_in(sh3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_last(out_last3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] pack2(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] r;
        for (int i = 0; i < 128; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    function automatic logic [383:0] pack3(input logic [127:0] a, input logic [127:0] b, input logic [127:0] c);
        logic [383:0] r;
        for (int i = 0; i < 128; i++) begin
            r[3*i]   = a[i];
            r[3*i+1] = b[i];
            r[3*i+2] = c[i];
        end
        return r;
    endfunction

    // Expected stream of one d=2 ciphertext: share 0 columns 0..3, then share 1.
    task automatic push2(input logic [127:0] a, input logic [127:0] b, input bit final_last);
        for (int w = 0; w < 8; w++) begin
            logic [127:0] s;
            s = (w < 4) ? a : b;
            q2.push_back({final_last && (w == 7), s[32*(w%4) +: 32]});
        end
    endtask

    task automatic drain(input int budget, input bit toggle);
        int n;
        n = 0;
        while (q2.size() + q3.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            if (q2.size() + q3.size() != 0 && toggle) out_ready2 = ~out_ready2;
            n++;
        end
        checks++;
        if (q2.size() + q3.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q2.size() + q3.size());
            q2.delete();
            q3.delete();
        end
    endtask

    task automatic capture2(input logic [255:0] v);
        @(posedge clk); #1;
        sh2 = v;
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
    endtask

    logic        stall2 = 1'b0;
    logic [31:0] held2;
    always @(negedge clk) begin
        logic [32:0] e;
        if (out_valid2) begin
            if (stall2) chk("stall_hold", out_data2, held2);
            if (out_ready2) begin
                stall2 = 1'b0;
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word2 actual=%0h required=none", out_data2);
                end else begin
                    e = q2.pop_front();
                    chk("word2", {out_last2, out_data2}, e);
                end
            end else begin
                stall2 = 1'b1;
                held2  = out_data2;
            end
        end else begin
            stall2 = 1'b0;
            chk("idle_zero2", {out_last2, out_data2}, 0);
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (out_valid3 && out_ready3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word3 actual=%0h required=none", out_data3);
            end else begin
                e = q3.pop_front();
                chk("word3", {out_last3, out_data3}, e);
                if (rx3_n < 12) rx3[rx3_n] = out_data3;
                rx3_n++;
            end
        end else if (!out_valid3) begin
            chk("idle_zero3", {out_last3, out_data3}, 0);
        end
    end

    logic [127:0] ca, cb, cc, cd, ce, cf, ct, r0, r1, r2;

    initial begin
        rst = 1'b1; sh2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        sh3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
        ca = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        cb = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
        cc = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        cd = 128'h11111111_22222222_33333333_44444444;
        ce = 128'hCAFEF00D_BAADC0DE_12345678_9ABCDEF0;
        cf = 128'h76543210_FEDCBA98_0BADBEEF_55AA55AA;

        // Reset behaviour, with valid input pending.
        in_valid2 = 1'b1; sh2 = pack2(ca, cb);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready2, 0);
        chk("rst_out_valid", out_valid2, 0);
        chk("rst_in_ready3", in_ready3, 0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid2 = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready2, 1);
        chk("post_rst_in_ready3", in_ready3, 1);

        // Single ciphertext, share1 = 0, out_ready high.
        push2(ca, 128'h0, 1'b1);
        capture2(pack2(ca, 128'h0));
        drain(40, 1'b0);
        @(negedge clk);
        chk("idle_after_last", out_valid2, 0);
        chk("idle_in_ready", in_ready2, 1);
        chk("idle_buf_clear", dut.buf_q[127:0], 0);

        // Stalled stream: out_ready toggles every cycle.
        push2(ca, cb, 1'b1);
        capture2(pack2(ca, cb));
        drain(60, 1'b1);
        out_ready2 = 1'b1;
        @(negedge clk);
        chk("stall_done_idle", out_valid2, 0);

        // Back-to-back ciphertexts with in_valid held high.
        push2(cc, cd, 1'b1);
        push2(ce, cf, 1'b1);
        @(posedge clk); #1;
        sh2 = pack2(cc, cd); in_valid2 = 1'b1;
        @(posedge clk); #1;
        sh2 = pack2(ce, cf);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_in_ready_%0d", i), in_ready2, (i == 7 || i == 15));
            chk($sformatf("b2b_valid_%0d", i), out_valid2, 1);
            @(posedge clk); #1;
            if (i == 14) in_valid2 = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_idle", out_valid2, 0);
        chk("b2b_queue_empty", q2.size(), 0);

        // in_valid during SEND must not overwrite the buffer.
        push2(cb, ca, 1'b1);
        @(posedge clk); #1;
        sh2 = pack2(cb, ca); in_valid2 = 1'b1;
        @(posedge clk); #1;
        sh2 = pack2(cd, cc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("busy_in_ready_%0d", i), in_ready2, 0);
            @(posedge clk); #1;
        end
        in_valid2 = 1'b0;
        drain(40, 1'b0);

        // Reset after the third word transfer.
        for (int w = 0; w < 3; w++) q2.push_back({1'b0, ce[32*w +: 32]});
        capture2(pack2(ce, cf));
        drain(40, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid2, 0);
        chk("midrst_in_ready", in_ready2, 0);
        chk("midrst_last", out_last2, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_buf_zero", dut.buf_q[255:128], 0);
        chk("midrst_buf_zero_lo", dut.buf_q[127:0], 0);
        chk("midrst_idle", out_valid2, 0);
        push2(cd, cc, 1'b1);
        capture2(pack2(cd, cc));
        drain(40, 1'b0);

        // d=3 random sharing; shares XOR to the ciphertext.
        ct = {$urandom, $urandom, $urandom, $urandom};
        r0 = {$urandom, $urandom, $urandom, $urandom};
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = ct ^ r0 ^ r1;
        for (int w = 0; w < 12; w++) begin
            logic [127:0] s;
            s = (w < 4) ? r0 : (w < 8) ? r1 : r2;
            q3.push_back({w == 11, s[32*(w%4) +: 32]});
        end
        @(posedge clk); #1;
        sh3 = pack3(r0, r1, r2); in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        drain(60, 1'b0);
        chk("d3_word_count", rx3_n, 12);
        for (int w = 0; w < 4; w++)
            chk($sformatf("d3_unmask_col%0d", w), rx3[w] ^ rx3[w+4] ^ rx3[w+8], ct[32*w +: 32]);
        repeat (3) @(negedge clk);
        chk("d3_idle", out_valid3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/smaesh_out_serializer.md
SMAESH_OUT_SERIALIZER -- requirements
Module: smaesh_out_serializer

Interface
REQ-001 SHALL have parameter d, default 2, meaning number of shares (d >= 2).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port sh_data_in, input, 128*d bits, masked ciphertext in dense sharing: share s of bit b at index b*d+s.
REQ-005 SHALL have port in_valid, input, 1 bit, high when sh_data_in is valid; driven by the core's out_valid.
REQ-006 SHALL have port in_ready, output, 1 bit, high when a new sharing can be captured; drives the core's out_ready.
REQ-007 SHALL have port out_data, output, 32 bits, current stream word.
REQ-008 SHALL have port out_valid, output, 1 bit, high when out_data is valid.
REQ-009 SHALL have port out_ready, input, 1 bit, downstream acceptance.
REQ-010 SHALL have port out_last, output, 1 bit, high with the final word of a ciphertext.

Function
REQ-011 SHALL implement two states: IDLE (buffer empty) and SEND (buffer holds one sharing).
REQ-012 SHALL hold a 128*d-bit buffer and a word counter cnt of width clog2(4*d), range 0..4*d-1.
REQ-013 SHALL assert in_ready in IDLE, and in SEND only when cnt == 4*d-1 and out_ready is high; this is a combinational path from out_ready.
REQ-014 SHALL capture sh_data_in into the buffer, set cnt to 0 and enter SEND on a cycle where in_valid && in_ready.
REQ-015 SHALL assert out_valid exactly while in SEND; first word valid the cycle after capture (latency 1).
REQ-016 SHALL output word w = cnt as share s = cnt / 4, column c = cnt % 4: out_data[k] = buffer[(32*c+k)*d + s], k = 0..31.
REQ-017 SHALL, when presenting a word, emit all four columns of share 0 first, then share 1, up to share d-1; 4*d words per ciphertext.
REQ-018 SHALL assert out_last iff in SEND and cnt == 4*d-1.
REQ-019 SHALL increment cnt on each out_valid && out_ready with cnt < 4*d-1; it SHALL hold out_data, cnt and out_valid stable while out_ready is low.
REQ-020 SHALL, on transfer of the last word with in_valid low, return to IDLE and clear the buffer to all zeros the same edge.
REQ-021 SHALL, on transfer of the last word with in_valid high, capture the new sharing, set cnt to 0 and remain in SEND (back-to-back; no bubble).
REQ-022 SHALL drive out_data to 0 whenever out_valid is low; never expose buffer contents outside SEND.
REQ-023 SHALL never combine two shares of the same bit in any logic; each out_data bit is a pure selection of a single buffer bit.

Reset
REQ-024 SHALL, on a clock edge with rst high, enter IDLE, set cnt to 0 and clear the buffer to all zeros, regardless of the current state (including mid-SEND).
REQ-025 SHALL, while rst is high, hold out_valid = 0, out_last = 0, out_data = 0 and in_ready = 0; the first cycle after rst falls, in_ready = 1.
REQ-026 SHALL discard any partially transmitted ciphertext on reset; no word of it reappears afterwards.

Verification
REQ-027 SHALL pass: d=2, one capture of sharing with share0 = 128'h00112233_44556677_8899AABB_CCDDEEFF and share1 = 0, out_ready always high -> 8 words 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233, then 4 x 0x00000000; out_last only on the 8th word; IDLE on the following cycle.
REQ-028 SHALL pass: out_ready toggling 1/0 each cycle during SEND -> the same 8 words in order with none duplicated or skipped; out_data stable during stalls.
REQ-029 SHALL pass: in_valid held high with two sharings back-to-back, out_ready high -> 16 contiguous valid words; in_ready high only on cycles 8 and 16 of the stream.
REQ-030 SHALL pass: rst asserted after the 3rd word transfer -> out_valid = 0 the next cycle, buffer reads zero, and the next capture restarts at word 0.
REQ-031 SHALL pass: in_valid high while in SEND with cnt < 7 -> in_ready = 0 and no capture; the buffer is unchanged.
REQ-032 SHALL pass: d=3, random sharing -> 12 words; XOR of words w, w+4 and w+8 for w = 0..3 equals unmasked ciphertext column w; out_data = 0 in every IDLE cycle.
